instr_sequencer: RTL and testbench
==================================

// Module: instr_sequencer
// PURPOSE
//   Program buffer and issue controller that feeds the 20-bit instruction port of the CPU datapath.
//   A host streams a program in over a valid/ready handshake. On start, the block issues one instruction
//   every ISSUE_GAP cycles, giving the multi-cycle CU/ALU/reg_mem path time to complete each one.
//   Issue stops on a HALT opcode or at the end of the loaded program.
// PARAMETERS
//   INSTR_WIDTH  20  instruction width; opcode = instr[INSTR_WIDTH-1 -: 4]
//   PROG_DEPTH   16  program buffer entries
//   PC_BITS      4   pointer width; PROG_DEPTH == 2**PC_BITS
//   ISSUE_GAP    3   cycles between issues, >= 1 (1 = back-to-back)
//   HALT_OP      4'hF  opcode that ends execution
// PORTS
//   clk         in   1            clock, rising edge
//   rst         in   1            asynchronous reset, active-low
//   load_valid  in   1            host has a program word on load_data
//   load_data   in   INSTR_WIDTH  program word
//   load_ready  out  1            buffer accepts a word this cycle
//   start       in   1            begin/restart execution at pc 0 (level, sampled per cycle)
//   clear       in   1            discard program, return to IDLE
//   instr_out   out  INSTR_WIDTH  instruction driven to the CPU
//   instr_valid out  1            one-cycle pulse: instr_out is a newly issued instruction
//   pc          out  PC_BITS      index of the last issued instruction
//   prog_count  out  PC_BITS+1    number of words loaded (0..PROG_DEPTH)
//   busy        out  1            high in RUN/GAP
//   done        out  1            high in DONE
// BEHAVIOUR
//   Reset (rst==0, async): state=IDLE; instr_out=0 (NOP); instr_valid=0; pc=0; prog_count=0; busy=0; done=0.
//     load_ready=1 the first cycle after release. Buffer contents are not reset.
//   FSM states: IDLE, RUN, GAP, DONE. clear is checked first in every state: it wins over start and load,
//     forces IDLE next cycle, sets prog_count=0, pc=0, instr_out=0.
//   IDLE:
//     load_ready = (prog_count < PROG_DEPTH).
//     Transfer when load_valid & load_ready: mem[prog_count] <= load_data; prog_count++.
//     At prog_count==PROG_DEPTH, load_ready=0 and further words are not accepted (no wrap).
//     start with prog_count>0 -> RUN. start with prog_count==0 is ignored.
//     If start and a transfer occur in the same cycle, the word is written and counted first,
//       and the program includes it.
//   RUN (1 cycle):
//     instr_out <= mem[pc_next]; instr_valid <= 1; pc <= pc_next.
//     pc_next = 0 on entry from IDLE/DONE, else pc+1.
//     Latency: first instr_valid is exactly 1 cycle after start is sampled.
//   Issue decision, made on the issued word:
//     opcode==HALT_OP, or pc==prog_count-1 -> DONE after ISSUE_GAP-1 GAP cycles (direct if ISSUE_GAP==1).
//     Otherwise -> GAP for ISSUE_GAP-1 cycles, then RUN.
//   GAP: instr_valid=0; instr_out holds the last issued word, stable for the CPU; counter down-counts.
//   DONE: done=1; instr_out=0.
//     start -> RUN with pc restarting at 0; program is retained.
//     load_valid is not accepted outside IDLE (load_ready=0 in RUN/GAP/DONE).
//   HALT word is itself issued (instr_valid pulses) before DONE.
//   Reset asserted mid-run: all outputs take reset values immediately; the program must be reloaded.
// CONFIGURATION
//   SEQ_SINGLE_STEP_EN defined:
//     adds input `step` (1 bit) and input `step_mode` (1 bit).
//     With step_mode=1, leaving GAP (or IDLE/DONE via start) additionally requires a step pulse.
//       Each step=1 cycle releases exactly one issue. Steps received in RUN are ignored.
//     With step_mode=0, behaviour is as above.
//   SEQ_SINGLE_STEP_EN not defined: no step/step_mode ports; free-running issue only.
// TESTING
//   1. Reset release, no stimulus -> load_ready=1, instr_valid=0, done=0, instr_out=20'h0, prog_count=0.
//   2. Load 3 words 20'h1_0203, 20'h2_0405, 20'h3_0106; start; ISSUE_GAP=3 -> instr_valid at t+1, t+4, t+7
//      with those words and pc 0,1,2. done=1 at t+9; busy low from t+9.
//   3. Load 20'h1_0001, 20'hF_0000, 20'h2_0002; start -> two issues only (2nd is HALT), done=1, pc=1,
//      the third word is never issued.
//   4. Load 16 words with load_valid held high -> load_ready drops after the 16th transfer.
//      17th word is not accepted; prog_count=16.
//   5. clear and start together while in GAP -> IDLE next cycle, prog_count=0, no further instr_valid.
//      start alone afterward is ignored.
//   6. Assert rst low mid-GAP (asynchronously, between edges) -> outputs are at reset values before the
//      next edge. With SEQ_SINGLE_STEP_EN and step_mode=1, each step pulse yields exactly one instr_valid.

Source files
------------

// File: rtl/instr_sequencer.sv
// Program buffer and issue controller for the CPU instruction port.
// A host loads words over a valid/ready handshake while idle. On start, one word is issued every
// ISSUE_GAP cycles until a HALT opcode or the last loaded word has been issued.
// Optional feature macro: SEQ_SINGLE_STEP_EN adds i_step/i_step_mode so each issue can be gated
// by a single-cycle step pulse.
module instr_sequencer #(
  parameter int unsigned INSTR_WIDTH = 20,
  parameter int unsigned PROG_DEPTH  = 16,
  parameter int unsigned PC_BITS     = 4,
  parameter int unsigned ISSUE_GAP   = 3,
  parameter logic [3:0]  HALT_OP     = 4'hF
) (
  input  logic                   i_clk,
  input  logic                   i_rst_n,
  input  logic                   i_load_valid,
  input  logic [INSTR_WIDTH-1:0] i_load_data,
  output logic                   o_load_ready,
  input  logic                   i_start,
  input  logic                   i_clear,
`ifdef SEQ_SINGLE_STEP_EN
  input  logic                   i_step,
  input  logic                   i_step_mode,
`endif
  output logic [INSTR_WIDTH-1:0] o_instr_out,
  output logic                   o_instr_valid,
  output logic [PC_BITS-1:0]     o_pc,
  output logic [PC_BITS:0]       o_prog_count,
  output logic                   o_busy,
  output logic                   o_done
);

  localparam int unsigned CNT_W = (ISSUE_GAP > 2) ? $clog2(ISSUE_GAP) : 1;
  // GAP lasts ISSUE_GAP-1 cycles: counter loads ISSUE_GAP-2 and leaves GAP when it reads zero.
  localparam logic [CNT_W-1:0] GAP_LOAD = (ISSUE_GAP >= 2) ? CNT_W'(ISSUE_GAP - 2) : '0;
  localparam logic [PC_BITS:0] DEPTH_V  = (PC_BITS + 1)'(PROG_DEPTH);

  typedef enum logic [1:0] {StIdle, StRun, StGap, StDone} state_e;

  state_e                 r_state, w_state_nxt;
  logic [PC_BITS-1:0]     r_ptr, w_ptr_nxt;     // index of the next word to issue
  logic [PC_BITS-1:0]     r_pc, w_pc_nxt;       // index of the last issued word
  logic [PC_BITS:0]       r_prog_count, w_prog_count_nxt;
  logic [INSTR_WIDTH-1:0] r_instr, w_instr_nxt;
  logic                   r_valid, w_valid_nxt;
  logic [CNT_W-1:0]       r_gap_cnt, w_gap_cnt_nxt;
  logic                   r_last, w_last_nxt;   // word just issued ends the program
  logic [INSTR_WIDTH-1:0] r_mem [PROG_DEPTH];

  logic                   w_go;
  logic                   w_step_mode;
  logic                   w_xfer;
  logic                   w_wr_en;
  logic [INSTR_WIDTH-1:0] w_issue_word;
  logic [PC_BITS:0]       w_last_idx;
  logic                   w_is_last;

`ifdef SEQ_SINGLE_STEP_EN
  assign w_step_mode = i_step_mode;
  assign w_go        = ~i_step_mode | i_step;
`else
  assign w_step_mode = 1'b0;
  assign w_go        = 1'b1;
`endif

  assign o_load_ready = (r_state == StIdle) && (r_prog_count < DEPTH_V) && !i_clear;
  assign w_xfer       = o_load_ready && i_load_valid;
  assign w_issue_word = r_mem[r_ptr];
  assign w_last_idx   = r_prog_count - (PC_BITS + 1)'(1);
  assign w_is_last    = (w_issue_word[INSTR_WIDTH-1 -: 4] == HALT_OP) ||
                        ({1'b0, r_ptr} == w_last_idx);

  // Next-state and next-output logic; clear overrides every state.
  always_comb begin
    w_state_nxt      = r_state;
    w_ptr_nxt        = r_ptr;
    w_pc_nxt         = r_pc;
    w_prog_count_nxt = r_prog_count;
    w_instr_nxt      = r_instr;
    w_valid_nxt      = 1'b0;
    w_gap_cnt_nxt    = r_gap_cnt;
    w_last_nxt       = r_last;
    w_wr_en          = 1'b0;
    if (i_clear) begin
      w_state_nxt      = StIdle;
      w_prog_count_nxt = '0;
      w_pc_nxt         = '0;
      w_ptr_nxt        = '0;
      w_instr_nxt      = '0;
    end else begin
      unique case (r_state)
        StIdle: begin
          if (w_xfer) begin
            w_wr_en          = 1'b1;
            w_prog_count_nxt = r_prog_count + (PC_BITS + 1)'(1);
          end
          // A word transferred in the same cycle counts towards the program.
          if (i_start && w_go && ((r_prog_count != '0) || w_xfer)) begin
            w_state_nxt = StRun;
            w_ptr_nxt   = '0;
          end
        end
        StRun: begin
          w_instr_nxt = w_issue_word;
          w_valid_nxt = 1'b1;
          w_pc_nxt    = r_ptr;
          w_ptr_nxt   = r_ptr + PC_BITS'(1);
          w_last_nxt  = w_is_last;
          // Step mode always parks in GAP so a step pulse can release the next issue.
          if ((ISSUE_GAP > 1) || w_step_mode) begin
            w_state_nxt   = StGap;
            w_gap_cnt_nxt = GAP_LOAD;
          end else if (w_is_last) begin
            w_state_nxt = StDone;
          end else begin
            w_state_nxt = StRun;
          end
        end
        StGap: begin
          if (r_gap_cnt != '0) begin
            w_gap_cnt_nxt = r_gap_cnt - CNT_W'(1);
          end else if (r_last) begin
            w_state_nxt = StDone;
            w_instr_nxt = '0;
          end else if (w_go) begin
            w_state_nxt = StRun;
          end
        end
        StDone: begin
          w_instr_nxt = '0;
          if (i_start && w_go) begin
            w_state_nxt = StRun;
            w_ptr_nxt   = '0;
          end
        end
        default: w_state_nxt = StIdle;
      endcase
    end
  end

  // Control and output registers, asynchronously reset.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state      <= StIdle;
      r_ptr        <= '0;
      r_pc         <= '0;
      r_prog_count <= '0;
      r_instr      <= '0;
      r_valid      <= 1'b0;
      r_gap_cnt    <= '0;
      r_last       <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_ptr        <= w_ptr_nxt;
      r_pc         <= w_pc_nxt;
      r_prog_count <= w_prog_count_nxt;
      r_instr      <= w_instr_nxt;
      r_valid      <= w_valid_nxt;
      r_gap_cnt    <= w_gap_cnt_nxt;
      r_last       <= w_last_nxt;
    end
  end

  // Program buffer write port; contents survive reset by design.
  always_ff @(posedge i_clk) begin
    if (w_wr_en) begin
      r_mem[r_prog_count[PC_BITS-1:0]] <= i_load_data;
    end
  end

  assign o_instr_out   = r_instr;
  assign o_instr_valid = r_valid;
  assign o_pc          = r_pc;
  assign o_prog_count  = r_prog_count;
  assign o_busy        = (r_state == StRun) || (r_state == StGap);
  assign o_done        = (r_state == StDone);

endmodule

// File: tb/tb_instr_sequencer.sv
// Directed, table-driven bench for instr_sequencer with ISSUE_GAP=3, depth 16.
module tb_instr_sequencer;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        load_valid;
  logic [19:0] load_data;
  logic        load_ready;
  logic        start;
  logic        clear;
  logic [19:0] instr_out;
  logic        instr_valid;
  logic [3:0]  pc;
  logic [4:0]  prog_count;
  logic        busy;
  logic        done;
`ifdef SEQ_SINGLE_STEP_EN
  logic        step;
  logic        step_mode;
`endif

  int n_cmp = 0;
  int n_err = 0;

  instr_sequencer #(
    .INSTR_WIDTH(20),
    .PROG_DEPTH (16),
    .PC_BITS    (4),
    .ISSUE_GAP  (3),
    .HALT_OP    (4'hF)
  ) dut (
    .i_clk        (clk),
    .i_rst_n      (rst_n),
    .i_load_valid (load_valid),
    .i_load_data  (load_data),
    .o_load_ready (load_ready),
    .i_start      (start),
    .i_clear      (clear),
`ifdef SEQ_SINGLE_STEP_EN
    .i_step       (step),
    .i_step_mode  (step_mode),
`endif
    .o_instr_out  (instr_out),
    .o_instr_valid(instr_valid),
    .o_pc         (pc),
    .o_prog_count (prog_count),
    .o_busy       (busy),
    .o_done       (done)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        start;
    logic        exp_valid;
    logic        exp_busy;
    logic        exp_done;
    logic [3:0]  exp_pc;
    logic [19:0] exp_instr;
  } vec_t;

  vec_t vecs [12];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load_word(input logic [19:0] d);
    load_valid = 1'b1;
    load_data  = d;
    #1;
    check("load_ready_idle", 64'(load_ready), 64'd1);
    @(posedge clk);
    #1;
    load_valid = 1'b0;
  endtask

  task automatic do_clear();
    clear = 1'b1;
    tick();
    clear = 1'b0;
  endtask

  task automatic load_prog2();
    load_word(20'h1_0203);
    load_word(20'h2_0405);
    load_word(20'h3_0106);
  endtask

  task automatic wait_done(input int budget, output int issues, output logic [19:0] last);
    issues = 0;
    last   = '0;
    for (int c = 0; c < budget; c++) begin
      tick();
      if (instr_valid) begin
        issues++;
        last = instr_out;
      end
      if (done) break;
    end
    check("done_reached", 64'(done), 64'd1);
  endtask

  int          issues;
  logic [19:0] last_w;
  int          acc;
  int          pulses;

  initial begin
    rst_n      = 1'b0;
    load_valid = 1'b0;
    load_data  = '0;
    start      = 1'b0;
    clear      = 1'b0;
`ifdef SEQ_SINGLE_STEP_EN
    step       = 1'b0;
    step_mode  = 1'b0;
`endif
    // start, valid, busy, done, pc, instr seen in the cycle after each edge
    vecs[0]  = '{1'b1, 1'b0, 1'b1, 1'b0, 4'd0, 20'h0_0000};
    vecs[1]  = '{1'b0, 1'b1, 1'b1, 1'b0, 4'd0, 20'h1_0203};
    vecs[2]  = '{1'b0, 1'b0, 1'b1, 1'b0, 4'd0, 20'h1_0203};
    vecs[3]  = '{1'b0, 1'b0, 1'b1, 1'b0, 4'd0, 20'h1_0203};
    vecs[4]  = '{1'b0, 1'b1, 1'b1, 1'b0, 4'd1, 20'h2_0405};
    vecs[5]  = '{1'b0, 1'b0, 1'b1, 1'b0, 4'd1, 20'h2_0405};
    vecs[6]  = '{1'b0, 1'b0, 1'b1, 1'b0, 4'd1, 20'h2_0405};
    vecs[7]  = '{1'b0, 1'b1, 1'b1, 1'b0, 4'd2, 20'h3_0106};
    vecs[8]  = '{1'b0, 1'b0, 1'b1, 1'b0, 4'd2, 20'h3_0106};
    vecs[9]  = '{1'b0, 1'b0, 1'b0, 1'b1, 4'd2, 20'h0_0000};
    vecs[10] = '{1'b1, 1'b0, 1'b1, 1'b0, 4'd2, 20'h0_0000};
    vecs[11] = '{1'b0, 1'b1, 1'b1, 1'b0, 4'd0, 20'h1_0203};

    // Reset release
    tick();
    tick();
    rst_n = 1'b1;
    #1;
    check("reset_outputs", {load_ready, instr_valid, busy, done, pc, prog_count, instr_out},
          {1'b1, 1'b0, 1'b0, 1'b0, 4'd0, 5'd0, 20'h0});

    // Three-word program, timing table, then restart from DONE
    load_prog2();
    check("prog_count_3", 64'(prog_count), 64'd3);
    for (int i = 0; i < 12; i++) begin
      start = vecs[i].start;
      tick();
      check($sformatf("vec%0d", i), {instr_valid, busy, done, pc, instr_out},
            {vecs[i].exp_valid, vecs[i].exp_busy, vecs[i].exp_done, vecs[i].exp_pc,
             vecs[i].exp_instr});
    end
    start = 1'b0;
    wait_done(20, issues, last_w);
    check("restart_issues", 64'(issues), 64'd2);
    check("restart_last", 64'(last_w), 64'h3_0106);

    // HALT in the middle of the program
    do_clear();
    check("clear_state", {busy, done, prog_count, pc, instr_out}, {1'b0, 1'b0, 5'd0, 4'd0, 20'h0});
    load_word(20'h1_0001);
    load_word(20'hF_0000);
    load_word(20'h2_0002);
    start = 1'b1;
    tick();
    start = 1'b0;
    wait_done(20, issues, last_w);
    check("halt_issues", 64'(issues), 64'd2);
    check("halt_last", 64'(last_w), 64'hF_0000);
    check("halt_pc", 64'(pc), 64'd1);
    check("halt_load_ready", 64'(load_ready), 64'd0);

    // Full buffer with load_valid held high
    do_clear();
    acc = 0;
    for (int i = 0; i < 17; i++) begin
      load_valid = 1'b1;
      load_data  = 20'h0_1000 + 20'(i);
      #1;
      if (load_ready) acc++;
      if (i == 16) check("full_ready_low", 64'(load_ready), 64'd0);
      tick();
    end
    load_valid = 1'b0;
    check("full_accepted", 64'(acc), 64'd16);
    check("full_prog_count", 64'(prog_count), 64'd16);
    start = 1'b1;
    tick();
    start = 1'b0;
    wait_done(80, issues, last_w);
    check("full_issues", 64'(issues), 64'd16);
    check("full_last", 64'(last_w), 64'h0_100F);
    check("full_pc", 64'(pc), 64'd15);

    // clear and start together in GAP
    do_clear();
    load_prog2();
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    clear = 1'b1;
    start = 1'b1;
    tick();
    clear = 1'b0;
    check("clear_in_gap", {instr_valid, busy, done, prog_count, pc, instr_out},
          {1'b0, 1'b0, 1'b0, 5'd0, 4'd0, 20'h0});
    pulses = 0;
    for (int i = 0; i < 4; i++) begin
      tick();
      if (instr_valid || busy) pulses++;
    end
    start = 1'b0;
    check("start_empty_ignored", 64'(pulses), 64'd0);

    // start and the first transfer in the same cycle
    load_valid = 1'b1;
    load_data  = 20'h5_0A0B;
    start      = 1'b1;
    tick();
    load_valid = 1'b0;
    start      = 1'b0;
    check("same_cycle_run", {busy, prog_count}, {1'b1, 5'd1});
    tick();
    check("same_cycle_issue", {instr_valid, pc, instr_out}, {1'b1, 4'd0, 20'h5_0A0B});
    wait_done(10, issues, last_w);

    // Asynchronous reset in the middle of GAP
    do_clear();
    load_prog2();
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    #2;
    rst_n = 1'b0;
    #1;
    check("async_reset", {load_ready, instr_valid, busy, done, pc, prog_count, instr_out},
          {1'b1, 1'b0, 1'b0, 1'b0, 4'd0, 5'd0, 20'h0});
    tick();
    rst_n = 1'b1;
    tick();

`ifdef SEQ_SINGLE_STEP_EN
    load_prog2();
    step_mode = 1'b1;
    start     = 1'b1;
    repeat (3) tick();
    check("step_start_held", 64'(busy), 64'd0);
    step = 1'b1;
    tick();
    step  = 1'b0;
    start = 1'b0;
    pulses = 0;
    for (int i = 0; i < 8; i++) begin
      tick();
      if (instr_valid) pulses++;
    end
    check("step_first_issue", 64'(pulses), 64'd1);
    pulses = 0;
    step = 1'b1;
    for (int i = 0; i < 6; i++) begin
      tick();
      step = 1'b0;
      if (instr_valid) pulses++;
    end
    check("step_second_issue", 64'(pulses), 64'd1);
    check("step_pc", 64'(pc), 64'd1);
    step_mode = 1'b0;
    wait_done(20, issues, last_w);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
